// File: rtl/generic_staging_pkg.sv
// Shared helpers for the staged valid/ready receive path.
package generic_staging_pkg;

   function automatic int staging_skid(input int stage_depth,
                                       input int rdy_depth);
      return stage_depth + rdy_depth + 1;
   endfunction

   function automatic int ptr_wrap(input int ptr, input int depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/generic_sync_fifo_core.sv
// Circular-buffer FIFO core: storage, pointers, occupancy.
module generic_sync_fifo_core
   import generic_staging_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CW-1:0]    o_count,
   output logic [CW-1:0]    o_count_next,
   output logic             o_empty,
   output logic             o_wr_ok
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_full;
   logic             w_empty;
   logic             w_rd;
   logic             w_wr;
   logic [CW-1:0]    w_count_next;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_rd    = i_pop & ~w_empty;
   // A full FIFO still takes a beat when the head leaves the same cycle
   assign w_wr    = i_push & (~w_full | w_rd);

   assign w_count_next = r_count + CW'(w_wr) - CW'(w_rd);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr)
            r_wr_ptr <= AW'(ptr_wrap(int'(r_wr_ptr), DEPTH));
         if (w_rd)
            r_rd_ptr <= AW'(ptr_wrap(int'(r_rd_ptr), DEPTH));
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata      = r_mem[r_rd_ptr];
   assign o_count      = r_count;
   assign o_count_next = w_count_next;
   assign o_empty      = w_empty;
   assign o_wr_ok      = w_wr;

endmodule

// File: rtl/generic_staging_rx_buffer.sv
// Receive terminator for a staged valid/data link: skid FIFO,
// registered up_rdy threshold and sticky overflow flag.
module generic_staging_rx_buffer
   import generic_staging_pkg::*;
#(
   parameter  int WIDTH       = 8,
   parameter  int STAGE_DEPTH = 2,
   parameter  int RDY_DEPTH   = 2,
   parameter  int FIFO_DEPTH  = 16,
   localparam int SKID        = staging_skid(STAGE_DEPTH, RDY_DEPTH),
   localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_data,
   output logic             up_rdy,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_rdy,
   output logic [CW-1:0]    count,
   output logic             overflow
);

   if (FIFO_DEPTH <= SKID) begin : g_depth_chk
      $fatal(1, "generic_staging_rx_buffer: FIFO_DEPTH must exceed SKID");
   end

   logic          r_up_rdy;
   logic          r_overflow;
   logic          w_empty;
   logic          w_wr_ok;
   logic [CW-1:0] w_count_next;

   generic_sync_fifo_core #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_core (
      .clk          (clk),
      .rst          (rst),
      .i_push       (in_vld),
      .i_pop        (out_rdy),
      .i_wdata      (in_data),
      .o_rdata      (out_data),
      .o_count      (count),
      .o_count_next (w_count_next),
      .o_empty      (w_empty),
      .o_wr_ok      (w_wr_ok)
   );

   // Keep room for every beat that can still be in flight once ready drops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_up_rdy   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_up_rdy   <= (FIFO_DEPTH - int'(w_count_next)) > SKID;
         r_overflow <= r_overflow | (in_vld & ~w_wr_ok);
      end
   end

   assign up_rdy   = r_up_rdy;
   assign out_vld  = ~w_empty;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_generic_staging_rx_buffer.sv
// Closed-loop and directed checks of generic_staging_rx_buffer.
module tb_generic_staging_rx_buffer;

   localparam int DA = 16;
   localparam int SA = 5;
   localparam int DB = 6;
   localparam int SB = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // DUT A: defaults (16 deep, 2+2 staging)
   logic       rst_a = 1'b1;
   logic       a_in_vld;
   logic [7:0] a_in_data;
   logic       a_up_rdy;
   logic       a_out_vld;
   logic [7:0] a_out_data;
   logic       a_out_rdy = 1'b0;
   logic [4:0] a_count;
   logic       a_overflow;

   // DUT B: 6 deep, no staging
   logic       rst_b = 1'b1;
   logic       b_in_vld = 1'b0;
   logic [7:0] b_in_data = '0;
   logic       b_up_rdy;
   logic       b_out_vld;
   logic [7:0] b_out_data;
   logic       b_out_rdy = 1'b0;
   logic [2:0] b_count;
   logic       b_overflow;

   generic_staging_rx_buffer u_dut_a (
      .clk      (clk),
      .rst      (rst_a),
      .in_vld   (a_in_vld),
      .in_data  (a_in_data),
      .up_rdy   (a_up_rdy),
      .out_vld  (a_out_vld),
      .out_data (a_out_data),
      .out_rdy  (a_out_rdy),
      .count    (a_count),
      .overflow (a_overflow)
   );

   generic_staging_rx_buffer #(
      .WIDTH       (8),
      .STAGE_DEPTH (0),
      .RDY_DEPTH   (0),
      .FIFO_DEPTH  (DB)
   ) u_dut_b (
      .clk      (clk),
      .rst      (rst_b),
      .in_vld   (b_in_vld),
      .in_data  (b_in_data),
      .up_rdy   (b_up_rdy),
      .out_vld  (b_out_vld),
      .out_data (b_out_data),
      .out_rdy  (b_out_rdy),
      .count    (b_count),
      .overflow (b_overflow)
   );

   // Closed-loop harness for DUT A: greedy upstream behind staging
   logic       loop_en = 1'b0;
   int         src_cnt;
   int         src_lim = 0;
   logic       src_v;
   logic [1:0] rdy_d;
   logic [1:0] fv;
   logic [7:0] fd [2];
   logic       d_vld = 1'b0;
   logic [7:0] d_data = '0;

   assign src_v = loop_en && rdy_d[1] && (src_cnt < src_lim);

   always @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         rdy_d   <= '0;
         fv      <= '0;
         src_cnt <= 0;
      end else begin
         rdy_d <= {rdy_d[0], a_up_rdy};
         fv    <= {fv[0], src_v};
         fd[0] <= src_cnt[7:0];
         fd[1] <= fd[0];
         if (src_v) src_cnt <= src_cnt + 1;
      end
   end

   assign a_in_vld  = loop_en ? fv[1] : d_vld;
   assign a_in_data = loop_en ? fd[1] : d_data;

   // Reference models: plain queues with the FIFO rules
   logic [7:0] qa[$];
   logic [7:0] rxa[$];
   bit         ovf_a, rdy_a, pop_a, acc_a;
   logic [7:0] qb[$];
   logic [7:0] rxb[$];
   bit         ovf_b, rdy_b, pop_b, acc_b;

   always @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         qa.delete(); rxa.delete(); ovf_a = 0; rdy_a = 0;
      end else begin
         pop_a = (qa.size() > 0) && a_out_rdy;
         acc_a = a_in_vld && ((qa.size() < DA) || pop_a);
         if (pop_a) rxa.push_back(qa.pop_front());
         if (acc_a) qa.push_back(a_in_data);
         if (a_in_vld && !acc_a) ovf_a = 1;
         rdy_a = (DA - qa.size()) > SA;
      end
   end

   always @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         qb.delete(); rxb.delete(); ovf_b = 0; rdy_b = 0;
      end else begin
         pop_b = (qb.size() > 0) && b_out_rdy;
         acc_b = b_in_vld && ((qb.size() < DB) || pop_b);
         if (pop_b) rxb.push_back(qb.pop_front());
         if (acc_b) qb.push_back(b_in_data);
         if (b_in_vld && !acc_b) ovf_b = 1;
         rdy_b = (DB - qb.size()) > SB;
      end
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(string t);
      chk({t, ".count"}, 32'(a_count), 32'(qa.size()));
      chk({t, ".vld"}, 32'(a_out_vld), 32'(qa.size() > 0));
      if (qa.size() > 0) chk({t, ".data"}, 32'(a_out_data), 32'(qa[0]));
      chk({t, ".ovf"}, 32'(a_overflow), 32'(ovf_a));
      chk({t, ".rdy"}, 32'(a_up_rdy), 32'(rdy_a));
   endtask

   task automatic chk_b(string t);
      chk({t, ".count"}, 32'(b_count), 32'(qb.size()));
      chk({t, ".vld"}, 32'(b_out_vld), 32'(qb.size() > 0));
      if (qb.size() > 0) chk({t, ".data"}, 32'(b_out_data), 32'(qb[0]));
      chk({t, ".ovf"}, 32'(b_overflow), 32'(ovf_b));
      chk({t, ".rdy"}, 32'(b_up_rdy), 32'(rdy_b));
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic reset_a();
      loop_en = 0; d_vld = 0; d_data = '0; a_out_rdy = 0; src_lim = 0;
      tick(); rst_a = 1;
      tick(); rst_a = 0;
   endtask

   task automatic reset_b();
      b_in_vld = 0; b_in_data = '0; b_out_rdy = 0;
      tick(); rst_b = 1;
      tick(); rst_b = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int maxc;
      int c11;
      int nsent;
      logic [7:0] sent[$];

      // Reset release
      reset_a();
      chk("rst.rdy0", 32'(a_up_rdy), 0);
      chk("rst.count0", 32'(a_count), 0);
      chk("rst.vld0", 32'(a_out_vld), 0);
      chk("rst.ovf0", 32'(a_overflow), 0);
      tick();
      chk("rst.rdy1", 32'(a_up_rdy), 1);
      chk("rst.vld1", 32'(a_out_vld), 0);
      chk("rst.count1", 32'(a_count), 0);

      // Streaming with constant out_rdy
      reset_a();
      a_out_rdy = 1; src_lim = 100; loop_en = 1; maxc = 0;
      for (int c = 0; c < 400 && rxa.size() < 100; c++) begin
         tick(); chk_a("stream");
         if (int'(a_count) > maxc) maxc = int'(a_count);
      end
      chk("stream.n", 32'(rxa.size()), 100);
      for (int i = 0; i < rxa.size(); i++) chk("stream.order", 32'(rxa[i]), 32'(i));
      chk("stream.maxcnt", 32'(maxc <= 2), 1);
      chk("stream.ovf", 32'(a_overflow), 0);

      // Greedy upstream, stalled consumer
      reset_a();
      a_out_rdy = 0; src_lim = 100000; loop_en = 1; maxc = 0; c11 = 0;
      for (int c = 0; c < 40; c++) begin
         tick(); chk_a("greedy");
         if (c11 == 0 && a_count == 5'd11) begin
            c11 = 1;
            chk("greedy.rdy_at_11", 32'(a_up_rdy), 0);
         end
         if (int'(a_count) > maxc) maxc = int'(a_count);
      end
      chk("greedy.seen11", 32'(c11), 1);
      chk("greedy.max16", 32'(maxc <= 16), 1);
      chk("greedy.skid5", 32'(maxc - 11 <= 5), 1);
      chk("greedy.ovf", 32'(a_overflow), 0);
      a_out_rdy = 1;
      for (int c = 0; c < 200 && rxa.size() < 20; c++) begin
         tick(); chk_a("drain");
      end
      chk("drain.n", 32'(rxa.size() >= 20), 1);
      for (int i = 0; i < 20 && i < rxa.size(); i++)
         chk("drain.order", 32'(rxa[i]), 32'(i));

      // Full FIFO: push+pop together, then a dropped beat
      reset_a();
      for (int i = 0; i < DA; i++) begin
         d_vld = 1; d_data = 8'(8'h40 + i);
         tick(); chk_a("fill");
      end
      chk("full.count", 32'(a_count), 16);
      d_data = 8'hAA; a_out_rdy = 1;
      tick(); chk_a("fullpp");
      chk("fullpp.count", 32'(a_count), 16);
      chk("fullpp.head", 32'(a_out_data), 32'h41);
      chk("fullpp.ovf", 32'(a_overflow), 0);
      d_data = 8'hBB; a_out_rdy = 0;
      tick(); chk_a("drop");
      chk("drop.count", 32'(a_count), 16);
      chk("drop.ovf", 32'(a_overflow), 1);
      chk("drop.head", 32'(a_out_data), 32'h41);
      d_vld = 0; a_out_rdy = 1;
      for (int i = 0; i < DA + 2; i++) begin
         tick(); chk_a("postdrop");
      end
      chk("sticky.vld", 32'(a_out_vld), 0);
      chk("sticky.ovf", 32'(a_overflow), 1);
      reset_a();
      chk("ovfclr", 32'(a_overflow), 0);

      // Random traffic across pointer wrap on the 6-deep instance
      reset_b();
      nsent = 0;
      for (int c = 0; c < 400 && rxb.size() < 20; c++) begin
         b_in_vld  = b_up_rdy && (nsent < 20) && ($urandom_range(3) != 0);
         b_in_data = 8'($urandom);
         if (b_in_vld) begin
            sent.push_back(b_in_data); nsent++;
         end
         b_out_rdy = ($urandom_range(2) != 0);
         tick(); chk_b("wrap");
      end
      b_in_vld = 0;
      chk("wrap.n", 32'(rxb.size()), 20);
      for (int i = 0; i < 20 && i < rxb.size(); i++)
         chk("wrap.order", 32'(rxb[i]), 32'(sent[i]));
      chk("wrap.ovf", 32'(b_overflow), 0);

      // Asynchronous reset with entries held
      b_out_rdy = 0;
      for (int i = 0; i < 4; i++) begin
         b_in_vld = 1; b_in_data = 8'(8'hC0 + i);
         tick(); chk_b("pre");
      end
      b_in_vld = 0;
      chk("pre.count", 32'(b_count), 4);
      #2; rst_b = 1; #1;
      chk("arst.count", 32'(b_count), 0);
      chk("arst.vld", 32'(b_out_vld), 0);
      chk("arst.rdy", 32'(b_up_rdy), 0);
      tick(); rst_b = 0;
      b_in_vld = 1; b_in_data = 8'h11;
      tick(); chk_b("post1");
      chk("post.head1", 32'(b_out_data), 32'h11);
      b_in_data = 8'h22;
      tick(); chk_b("post2");
      b_in_vld = 0; b_out_rdy = 1;
      tick(); chk_b("post3");
      chk("post.head2", 32'(b_out_data), 32'h22);
      chk("post.count", 32'(b_count), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/generic_staging_rx_buffer.md
Name: generic_staging_rx_buffer

Overview:
- Receive-end terminator for a staged (multi-flop, fixed-latency) valid/data link.
- Upstream drives in_vld/in_data only while the ready it sees is high. That ready reaches upstream through an external return staging of RDY_DEPTH flops, so beats keep arriving for a bounded round trip after up_rdy falls.
- This block absorbs those in-flight beats in a skid FIFO and re-presents them downstream on a valid/ready interface.
- Sits at the consumer side of any generic staging pipeline that crosses long routes.

Parameters:
- WIDTH, 8, payload width in bits.
- STAGE_DEPTH, 2, flop stages on the forward valid/data path, 0 allowed.
- RDY_DEPTH, 2, flop stages on the return ready path, 0 allowed.
- FIFO_DEPTH, 16, skid FIFO entries. Must be > SKID, checked at elaboration with a fatal error.
- SKID, localparam = STAGE_DEPTH + RDY_DEPTH + 1, worst-case beats in flight after up_rdy deasserts.

Ports:
- clk  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- in_vld  input  1  beat valid from the staged forward path.
- in_data  input  WIDTH  beat payload.
- up_rdy  output  1  registered permission-to-send, driven into the return staging.
- out_vld  output  1  FIFO non-empty.
- out_data  output  WIDTH  head entry.
- out_rdy  input  1  downstream accept.
- count  output  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  output  1  sticky error: a beat arrived while the FIFO was full.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: up_rdy=0, out_vld=0, count=0, overflow=0, read and write pointers 0. Storage is not reset; out_data is don't-care while out_vld=0.
- Reset asserted mid-operation flushes all entries immediately, with no drain.
- push = in_vld. pop = out_vld & out_rdy.
- Storage is a circular buffer.
  - Write pointer advances on an accepted push; read pointer advances on pop.
  - Both wrap from FIFO_DEPTH-1 to 0. Non-power-of-2 depths must be supported with explicit wrap compare.
- count_next = count + accepted_push - pop.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Full (count==FIFO_DEPTH):
  - A push is accepted only if pop is also asserted that cycle.
  - Otherwise the beat is dropped, no pointer or state changes, and overflow is set to 1.
  - overflow clears only on reset.
- Empty: out_vld=0 and pop cannot occur. A push to an empty FIFO makes out_vld=1 the next cycle (1-cycle in-to-out latency, no bypass).
- out_data = mem[rd_ptr], read combinationally from registered storage.
- up_rdy is registered: up_rdy <= (FIFO_DEPTH - count_next) > SKID.
  - First cycle after rst deasserts: up_rdy=0. Next cycle: up_rdy=1.
  - This guarantees no overflow with a compliant upstream under any out_rdy pattern.
- Full throughput is sustained only when FIFO_DEPTH >= 2*SKID. Below that, throughput degrades but stays correct.
- in_vld while up_rdy=0 is legal (in-flight beats) and is handled exactly like any other push.

Decomposition:
- Shared package generic_staging_pkg:
  - function staging_skid(stage_depth, rdy_depth) returning SKID.
  - function ptr_wrap(ptr, depth).
- Sub-module generic_sync_fifo_core (storage, pointers, count, full/empty).
  - This block adds the up_rdy threshold register and overflow sticky around it.
- Bench: verification instantiates generic_dff_staging on both in_vld/in_data (STAGE_DEPTH) and up_rdy (RDY_DEPTH) to build the closed loop.

Test Plan:
- Reset release with defaults -> cycle 0 after release: up_rdy=0, count=0. Cycle 1: up_rdy=1. out_vld=0 throughout.
- Closed loop, out_rdy=1 constantly, 100 beats with incrementing data 0x00..0x63 -> all received in order, count never exceeds 2, overflow=0.
- Closed loop, out_rdy=0 from start, upstream greedy:
  - up_rdy falls the cycle after count reaches 11.
  - At most 5 further beats arrive; count settles at 16 or below.
  - overflow=0. Releasing out_rdy drains 0x00.. in order.
- Full with simultaneous push+pop (FIFO_DEPTH=16, count=16, in_vld=1, out_rdy=1) -> count stays 16, head advances, overflow=0.
- Protocol violation: count=16, in_vld=1, out_rdy=0 -> beat dropped, count=16, overflow=1 next cycle and sticky until rst.
- Wrap and mid-op reset:
  - FIFO_DEPTH=6, STAGE_DEPTH=0, RDY_DEPTH=0, 20 random beats -> order preserved across pointer wrap.
  - Assert rst with count=4 -> count=0, out_vld=0 immediately. Post-reset beats start at rd_ptr 0.
